// File: rtl/ram_bus_arbiter.sv
// Shares the BaseRAM/ExtRAM SRAM pins between the IF and MEM stages, one access at a time.
// MEM wins simultaneous requests; each mapped access runs SETUP, then WAIT_CYCLES x STROBE, then DONE.
module ram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ready,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_data_q;
    logic        ext_q;
    logic        mapped_q;
    logic [19:0] addr_q;
    logic [3:0]  we_q;
    logic [31:0] wdata_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic        accept;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic        req_base, req_ext;
    logic        unused_byte_offset;

    always_comb begin
        req_addr = data_req ? data_addr : inst_addr;
        req_we   = data_req ? data_we : 4'b0000;
        req_base = (req_addr[31:22] == 10'h200);
        req_ext  = (req_addr[31:22] == 10'h201);
    end

    assign unused_byte_offset = ^req_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req || inst_req) begin
                    accept  = 1'b1;
                    state_d = (req_base || req_ext) ? SETUP : DONE;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 3'(WAIT_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 3'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic        is_write, sel_base, sel_ext, in_cycle, strobe;
    logic [31:0] capture;

    always_comb begin
        is_write = |we_q;
        sel_base = mapped_q && !ext_q;
        sel_ext  = mapped_q && ext_q;
        in_cycle = (state_q == SETUP) || (state_q == STROBE);
        strobe   = (state_q == STROBE);
        capture  = is_write ? '0 : (ext_q ? ext_ram_data : base_ram_data);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_data_q <= 1'b0;
            ext_q        <= 1'b0;
            mapped_q     <= 1'b0;
            addr_q       <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                owner_data_q <= data_req;
                ext_q        <= req_ext;
                mapped_q     <= req_base || req_ext;
                addr_q       <= req_addr[21:2];
                we_q         <= req_we;
                wdata_q      <= data_wdata;
                // Unmapped accesses skip the RAM and answer zero in DONE
                if (!(req_base || req_ext)) begin
                    if (data_req) data_rdata_q <= '0;
                    else          inst_rdata_q <= '0;
                end
            end
            if (strobe && cnt_q == '0) begin
                if (owner_data_q) data_rdata_q <= capture;
                else              inst_rdata_q <= capture;
            end
        end
    end

    assign inst_ready  = (state_q == IDLE);
    assign data_ready  = (state_q == IDLE);
    assign inst_rvalid = (state_q == DONE) && !owner_data_q;
    assign data_rvalid = (state_q == DONE) && owner_data_q;
    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;

    assign base_ram_addr = addr_q;
    assign base_ram_ce_n = !(sel_base && in_cycle);
    assign base_ram_oe_n = !(sel_base && strobe && !is_write);
    assign base_ram_we_n = !(sel_base && strobe && is_write);
    assign base_ram_be_n = (sel_base && strobe && is_write) ? ~we_q : 4'b0000;
    assign base_ram_data = (sel_base && is_write && state_q != IDLE) ? wdata_q : 32'bz;

    assign ext_ram_addr = addr_q;
    assign ext_ram_ce_n = !(sel_ext && in_cycle);
    assign ext_ram_oe_n = !(sel_ext && strobe && !is_write);
    assign ext_ram_we_n = !(sel_ext && strobe && is_write);
    assign ext_ram_be_n = (sel_ext && strobe && is_write) ? ~we_q : 4'b0000;
    assign ext_ram_data = (sel_ext && is_write && state_q != IDLE) ? wdata_q : 32'bz;

endmodule

// File: doc/ram_bus_arbiter.md
RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: number of strobe cycles per external SRAM access; legal range 1..7.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req  in  1; inst_addr  in  32: IF-stage read request and byte address.
REQ-005 inst_ready  out  1; inst_rvalid  out  1; inst_rdata  out  32: IF-stage accept, response pulse and read word.
REQ-006 data_req  in  1; data_we  in  4; data_addr  in  32; data_wdata  in  32: MEM-stage request, per-byte write enables (0000 = read), byte address and store data.
REQ-007 data_ready  out  1; data_rvalid  out  1; data_rdata  out  32: MEM-stage accept, response pulse and load word.
REQ-008 base_ram_data  inout  32; base_ram_addr  out  20; base_ram_be_n, base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  4/1/1/1: BaseRAM pins, strobes active-low.
REQ-009 ext_ram_data, ext_ram_addr, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n: ExtRAM pins, identical widths and semantics.

Function
REQ-010 Address map: 0x8000_0000-0x803F_FFFF selects BaseRAM, 0x8040_0000-0x807F_FFFF selects ExtRAM; RAM address = addr[21:2]; any other address is unmapped.
REQ-011 FSM states: IDLE, SETUP, STROBE, DONE; inst_ready = data_ready = (state==IDLE).
REQ-012 Accept in IDLE: when data_req=1, the data request is granted (fixed priority, MEM over IF); otherwise when inst_req=1, the inst request is granted; the losing request is not accepted and must be held by its master.
REQ-013 On accept: latch grant owner, target RAM, address, byte enables and wdata; go to SETUP (mapped) or DONE (unmapped).
REQ-014 SETUP (1 cycle): selected RAM ce_n=0, address driven, oe_n=1, we_n=1; for writes, data bus driven with latched wdata; go to STROBE, counter loaded with WAIT_CYCLES-1.
REQ-015 STROBE (WAIT_CYCLES cycles): read -> oe_n=0; write -> we_n=0 and be_n=~data_we; read be_n=4'b0000; counter decrements; exit to DONE when counter==0.
REQ-016 Read data sampled from selected RAM data bus on the clock edge that ends the last STROBE cycle and held in a register.
REQ-017 DONE (1 cycle): ce_n/oe_n/we_n deasserted, write data still driven (hold); owner's rvalid=1 for exactly this cycle with rdata = captured word (writes: rdata=0); go to IDLE.
REQ-018 Latency: mapped access accepted at edge T gives rvalid in cycle T+2+WAIT_CYCLES; unmapped access gives rvalid next cycle with rdata=0, no RAM strobe, writes dropped.
REQ-019 Unselected RAM: ce_n=oe_n=we_n=1, be_n=4'b0000, data bus high-Z; a RAM data bus is driven only during SETUP, STROBE and DONE of a write to it.
REQ-020 At most one access outstanding; both RAMs never strobed in the same cycle; requests arriving in SETUP/STROBE/DONE see ready=0.
REQ-021 inst_rvalid and data_rvalid are never high simultaneously; rdata outputs hold last value when rvalid=0.
REQ-022 An instruction fetch targeting ExtRAM and a load/store targeting BaseRAM are legal and use the same sequence.

Reset
REQ-023 resetn=0 immediately (asynchronously): state=IDLE, counter=0, all ce_n/oe_n/we_n=1, be_n=0000, data buses high-Z, rvalid=0, rdata=0, ready outputs 1 after release.
REQ-024 Reset asserted mid-access aborts it with no response pulse; first cycle after release accepts new requests.

Verification
REQ-025 Fetch 0x8000_0004, BaseRAM word 0x1234_5678, WAIT_CYCLES=1 -> base_ram_addr=0x00001, oe_n low one cycle, inst_rvalid 3 cycles after accept with 0x1234_5678.
REQ-026 Same cycle inst_req (0x8000_0000) and data_req read 0x8040_0010 -> data granted first (ext_ram_addr=0x00004), inst accepted in cycle after data_rvalid.
REQ-027 Store data_we=0011, wdata=0xAABB_CCDD to 0x8040_0008 -> ext_ram_be_n=1100 during we_n low, bus driven SETUP..DONE, data_rvalid one pulse, rdata=0.
REQ-028 Read 0x9000_0000 -> no ce_n asserted, data_rvalid next cycle, data_rdata=0.
REQ-029 WAIT_CYCLES=3 read: oe_n low exactly 3 cycles; resetn pulsed low during second STROBE cycle -> strobes high immediately, no rvalid, ready=1 after release.
